// File: rtl/program_loader.sv
// Byte-stream program loader: receives a framed, XOR-checksummed instruction image,
// buffers it, and writes it into the core's program port while holding the core in reset.
module program_loader #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned MAX_INSTR  = 32,
    localparam int unsigned CMD_WIDTH = 4 + ADDR_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [7:0]           in_data,
    output logic                 in_ready,
    output logic                 program_write,
    output logic [CMD_WIDTH-1:0] program_cmd,
    output logic                 core_reset,
    output logic                 loaded,
    output logic                 error
);

    localparam int unsigned B     = (CMD_WIDTH + 7) / 8;
    localparam int unsigned BCW   = (B > 1) ? $clog2(B) : 1;
    localparam int unsigned IW    = (MAX_INSTR > 1) ? $clog2(MAX_INSTR) : 1;
    localparam int unsigned AW    = (B > 1) ? (B - 1) * 8 : 1;
    localparam int unsigned LASTW = CMD_WIDTH - (B - 1) * 8;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_COUNT = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_CSUM  = 3'd3;
    localparam logic [2:0] S_CLEAR = 3'd4;
    localparam logic [2:0] S_FLUSH = 3'd5;

    logic [2:0]           state_q, state_d;
    logic [7:0]           n_q, n_d;
    logic [7:0]           idx_q, idx_d;
    logic [7:0]           f_q, f_d;
    logic [BCW-1:0]       byte_q, byte_d;
    logic [AW-1:0]        asm_q, asm_d;
    logic [7:0]           csum_q, csum_d;
    logic                 in_ready_q;
    logic                 pw_q, pw_d;
    logic [CMD_WIDTH-1:0] cmd_q, cmd_d;
    logic                 core_reset_q;
    logic                 loaded_q;
    logic                 error_q, error_d;
    logic                 clear_loaded, set_loaded;
    logic                 wr_en;
    logic                 accept;
    logic [CMD_WIDTH-1:0] word;

    logic [CMD_WIDTH-1:0] mem_q [MAX_INSTR];

    assign accept = in_valid && in_ready_q;

    // The final byte of an instruction completes the word directly from the input bus,
    // so the buffer write happens in the same cycle that byte is accepted.
    generate
        if (B > 1) begin : g_multi
            assign word = {in_data[LASTW-1:0], asm_q[(B-1)*8-1:0]};
        end else begin : g_single
            assign word = in_data[CMD_WIDTH-1:0];
        end
    endgenerate

    always_comb begin
        state_d      = state_q;
        n_d          = n_q;
        idx_d        = idx_q;
        f_d          = f_q;
        byte_d       = byte_q;
        asm_d        = asm_q;
        csum_d       = csum_q;
        pw_d         = 1'b0;
        cmd_d        = '0;
        error_d      = 1'b0;
        clear_loaded = 1'b0;
        set_loaded   = 1'b0;
        wr_en        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept && in_data == SYNC_BYTE) begin
                    state_d      = S_COUNT;
                    clear_loaded = 1'b1;
                end
            end
            S_COUNT: begin
                if (accept) begin
                    if (in_data == 8'd0 || 32'(in_data) > MAX_INSTR) begin
                        error_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        n_d     = in_data;
                        csum_d  = in_data;
                        idx_d   = '0;
                        byte_d  = '0;
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    csum_d = csum_q ^ in_data;
                    if (byte_q == BCW'(B - 1)) begin
                        wr_en  = 1'b1;
                        byte_d = '0;
                        idx_d  = idx_q + 8'd1;
                        if (idx_q == n_q - 8'd1) begin
                            state_d = S_CSUM;
                        end
                    end else begin
                        asm_d[8*int'(byte_q) +: 8] = in_data;
                        byte_d = byte_q + BCW'(1);
                    end
                end
            end
            S_CSUM: begin
                if (accept) begin
                    if (in_data == csum_q) begin
                        state_d = S_CLEAR;
                    end else begin
                        error_d = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_CLEAR: begin
                // Entry 0 is staged here so writes land on consecutive FLUSH cycles.
                pw_d    = 1'b1;
                cmd_d   = mem_q[0];
                f_d     = 8'd1;
                state_d = S_FLUSH;
            end
            S_FLUSH: begin
                if (f_q == n_q) begin
                    set_loaded = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    pw_d  = 1'b1;
                    cmd_d = mem_q[f_q[IW-1:0]];
                    f_d   = f_q + 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            n_q          <= '0;
            idx_q        <= '0;
            f_q          <= '0;
            byte_q       <= '0;
            asm_q        <= '0;
            csum_q       <= '0;
            in_ready_q   <= 1'b0;
            pw_q         <= 1'b0;
            cmd_q        <= '0;
            core_reset_q <= 1'b0;
            loaded_q     <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            idx_q        <= idx_d;
            f_q          <= f_d;
            byte_q       <= byte_d;
            asm_q        <= asm_d;
            csum_q       <= csum_d;
            in_ready_q   <= (state_d == S_IDLE) || (state_d == S_COUNT) ||
                            (state_d == S_DATA) || (state_d == S_CSUM);
            pw_q         <= pw_d;
            cmd_q        <= cmd_d;
            core_reset_q <= (state_d == S_CLEAR) || (state_d == S_FLUSH);
            error_q      <= error_d;
            if (set_loaded) begin
                loaded_q <= 1'b1;
            end else if (clear_loaded) begin
                loaded_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[idx_q[IW-1:0]] <= word;
        end
    end

    assign in_ready      = in_ready_q;
    assign program_write = pw_q;
    assign program_cmd   = cmd_q;
    assign core_reset    = core_reset_q;
    assign loaded        = loaded_q;
    assign error         = error_q;

endmodule

// File: doc/program_loader.md
# program_loader

Byte-stream program loader for the MC14500B system: it receives a framed, checksummed instruction image on a valid/ready byte interface, buffers it, and on a verified frame writes it into the `Wrapper` program port (`program_write`/`program_cmd`) while holding the core in reset. It is the writer side of the program interface that `Wrapper` only receives. It sits between a host link (UART RX, debug bridge) and `Wrapper`.

## Interface
- `ADDR_WIDTH`, 8: core address field width; `CMD_WIDTH = 4 + ADDR_WIDTH` (opcode in bits [CMD_WIDTH-1:ADDR_WIDTH]).
- `MAX_INSTR`, 32: buffer depth and maximum instructions per frame (1..255).
- `clk` in 1: single clock, all logic on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `in_valid` in 1: byte available.
- `in_data` in 8: byte.
- `in_ready` out 1: byte accepted when `in_valid && in_ready` on a rising edge.
- `program_write` out 1: one-cycle write strobe to `Wrapper`.
- `program_cmd` out CMD_WIDTH: instruction, valid when `program_write`=1, else 0.
- `core_reset` out 1: active-high reset to `Wrapper`.
- `loaded` out 1: level; a verified image has been written.
- `error` out 1: one-cycle pulse on a rejected frame.

## Operation
- Frame: `0xA5`, `N`, N instructions of `B = ceil(CMD_WIDTH/8)` bytes each (little-endian; bits above CMD_WIDTH in the last byte ignored), checksum byte = XOR of `N` and all instruction bytes (padding bits included).
- States: IDLE -> COUNT -> DATA -> CSUM -> CLEAR -> FLUSH -> IDLE; any state -> IDLE via error.
- IDLE: `in_ready`=1; non-`0xA5` bytes dropped silently; `0xA5` -> COUNT and clears `loaded`.
- COUNT: `N`=0 or `N`>MAX_INSTR -> `error` pulse, IDLE. Else store N, seed checksum with N, -> DATA.
- DATA: byte counter 0..B-1 assembles each instruction; the last byte writes the buffer at index i (0..N-1) in the same cycle; after instruction N-1 -> CSUM.
- CSUM: accept one byte; equal to the running XOR -> CLEAR, else `error` pulse, IDLE, buffer discarded.
- CLEAR: `in_ready`=0, `core_reset`=1, one cycle.
- FLUSH: `in_ready`=0, `core_reset`=1; one buffer entry per cycle, indices 0..N-1 in order, `program_write`=1. After the last write -> IDLE with `core_reset`=0 and `loaded`=1.
- `Wrapper` accepts program writes while held in reset and starts at address 0 on release.
- `core_reset`=0 in all states except CLEAR and FLUSH. The previous program keeps running while a new frame is received.
- An `0xA5` inside DATA/CSUM is treated as data, not a resync.

## Timing
- Reset values: `in_ready`=0 while `reset` low, 1 from the first edge after release (IDLE); `program_write`=0, `program_cmd`=0, `core_reset`=0, `loaded`=0, `error`=0; state IDLE.
- `in_ready` is registered: 1 in IDLE/COUNT/DATA/CSUM, 0 from the cycle after the checksum byte is accepted until FLUSH exits.
- Checksum byte accepted at edge T: CLEAR in cycle T+1, writes in cycles T+2..T+N+1, `core_reset` falls and `loaded` rises in cycle T+N+2, `in_ready`=1 in T+N+2.
- `error` is high in the cycle after the offending byte is accepted.
- Back-to-back bytes (`in_valid` held high) are accepted every cycle in receive states.
- Stalls (`in_valid`=0) are allowed anywhere in a frame. There is no timeout.
- Asserting `reset` mid-FLUSH stops writes immediately and clears `core_reset` and `loaded`. A partial image in `Wrapper` is the host's concern.

## Test plan
- ADDR_WIDTH=8 (B=2): frame `A5 02 34 12 78 56 0A` -> `program_cmd` 0x234 then 0x678 on consecutive cycles. `core_reset` is high for exactly 3 cycles starting the cycle after `0A` is accepted. `loaded`=1 after, `error` never pulses.
- Same frame with checksum `0B` -> one `error` pulse, no `program_write`, `core_reset` stays 0, `loaded` stays 0.
- `A5 00` and `A5 21` (MAX_INSTR=32) -> `error` pulse after the count byte. A following valid frame loads normally.
- Garbage `11 22 A5` then a valid 1-instruction frame `01 FF 0F F1` -> `program_cmd`=0xFFF written once. Preceding garbage is ignored.
- `in_valid` toggled every other cycle through a valid frame -> the same writes as the back-to-back case. `in_ready`=0 for every cycle of CLEAR/FLUSH.
- `reset` driven low during the second FLUSH write of a 4-instruction frame -> all outputs at reset values immediately. The next frame after release loads all entries from index 0.
